// File: rtl/demorgan_equiv_checker.sv
// demorgan_equiv_checker
// Drives all four {A,B} combinations into a NOT/OR and NOT/AND De Morgan
// pair and waits SETTLE_CYCLES per vector. On the CHECK cycle it compares
// the returned results with the golden functions. It reports a sticky
// per-vector fail map, a saturating error count and a pass verdict.
//
// Build option: define DEMORGAN_CHK_INTERM_EN to also check the
// intermediate complements nA/nB. Without it those ports are ignored.
//
// Handshake: `start` is a level request that is sampled only in IDLE.
// The run is in flight while `busy` is high. `done` pulses for one cycle,
// and `pass`/`err_count`/`fail_vec` stay valid from `done` until the next
// accepted `start`.
module demorgan_equiv_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             A,
    output logic             B,
    input  logic             nA,
    input  logic             nB,
    input  logic             nAandnB,
    input  logic             nAorB,
    input  logic             nAornB,
    input  logic             nAandB,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       fail_vec,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Counter widths are floored at 1 bit so degenerate parameters still elaborate
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [PW-1:0] PASS_LAST   = PW'((PASSES > 1) ? PASSES - 1 : 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_v;
    logic [PW-1:0]    r_p;
    logic [SW-1:0]    r_settle_cnt;
    logic             r_a;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_err;
    logic [3:0]       r_fail_vec;

    logic       w_last_vec;
    logic       w_last_pass;
    logic       w_settle_done;
    logic [1:0] w_v_inc;
    logic       w_g_or;
    logic       w_g_and;
    logic       w_core_fail;
    logic       w_interm_fail;
    logic       w_vec_fail;

    assign w_last_vec    = (r_v == 2'd3);
    assign w_last_pass   = (r_p == PASS_LAST);
    assign w_settle_done = (r_settle_cnt == SETTLE_LAST);
    assign w_v_inc       = r_v + 2'd1;

    // Golden results come from the vector currently on the A/B outputs
    assign w_g_or  = ~(r_a | r_b);
    assign w_g_and = ~(r_a & r_b);

    assign w_core_fail = (nAandnB != w_g_or)  | (nAorB  != w_g_or) |
                         (nAornB  != w_g_and) | (nAandB != w_g_and);

`ifdef DEMORGAN_CHK_INTERM_EN
    assign w_interm_fail = (nA != ~r_a) | (nB != ~r_b);
`else
    // nA/nB are not checked in this build; this sink only marks them as intentionally unused
    logic w_interm_unused;
    assign w_interm_unused = nA ^ nB;
    assign w_interm_fail   = 1'b0;
`endif

    // One vector counts as one failure, however many of its results are wrong
    assign w_vec_fail = w_core_fail | w_interm_fail;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (SETTLE_CYCLES > 0) begin
                    w_state_nxt = S_SETTLE;
                end else begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_SETTLE: begin
                if (w_settle_done) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_last_vec && w_last_pass) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRIVE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Vector/pass sequencing; A/B are loaded on the edge that enters DRIVE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v          <= 2'd0;
            r_p          <= '0;
            r_settle_cnt <= '0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_v <= 2'd0;
                        r_p <= '0;
                        r_a <= 1'b0;
                        r_b <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    r_settle_cnt <= '0;
                end
                S_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + SW'(1);
                end
                S_CHECK: begin
                    if (!w_last_vec) begin
                        r_v <= w_v_inc;
                        r_a <= w_v_inc[1];
                        r_b <= w_v_inc[0];
                    end else if (!w_last_pass) begin
                        r_v <= 2'd0;
                        r_p <= r_p + PW'(1);
                        r_a <= 1'b0;
                        r_b <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result accumulation: cleared on accepted start, updated on each CHECK edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err      <= '0;
            r_fail_vec <= 4'd0;
            r_pass     <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_err      <= '0;
                r_fail_vec <= 4'd0;
                r_pass     <= 1'b0;
            end else if (r_state == S_CHECK) begin
                if (w_vec_fail) begin
                    r_fail_vec[r_v] <= 1'b1;
                    if (r_err != '1) begin
                        r_err <= r_err + CNT_W'(1);
                    end
                end
                // Verdict is registered so it is already valid in the DONE cycle
                if (w_last_vec && w_last_pass) begin
                    r_pass <= (r_err == '0) && !w_vec_fail;
                end
            end
        end
    end

    // Registered status flags derived from the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_DRIVE) || (w_state_nxt == S_SETTLE) ||
                      (w_state_nxt == S_CHECK);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail_vec;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_demorgan_equiv_checker.sv
// Bench for demorgan_equiv_checker.
// Two instances are used. dut0 has the defaults (SETTLE=2, PASSES=1,
// CNT_W=8). dut1 has SETTLE=0, PASSES=2 and CNT_W=2. A fault-injectable
// gate model feeds the result inputs. Expected results come from a model
// that evaluates the gate rules over every vector of every pass.
module tb_demorgan_equiv_checker;

`ifdef DEMORGAN_CHK_INTERM_EN
    localparam bit INTERM = 1'b1;
`else
    localparam bit INTERM = 1'b0;
`endif

    localparam int S0 = 2, P0 = 1, W0 = 8;
    localparam int S1 = 0, P1 = 2, W1 = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start0, start1;

    // ---------------- DUT wiring ----------------
    logic       a0, b0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [3:0] fv0;
    logic [2:0] st0;
    logic       a1, b1, busy1, done1, pass1;
    logic [1:0] err1;
    logic [3:0] fv1;
    logic [2:0] st1;
    logic [5:0] gv0, gv1;       // bit order: nA, nB, nAandnB, nAorB, nAornB, nAandB
    logic [5:0] junk0, junk1;   // glitch masks applied outside CHECK cycles

    demorgan_equiv_checker #(.SETTLE_CYCLES(S0), .PASSES(P0), .CNT_W(W0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .A(a0), .B(b0),
        .nA(gv0[0]), .nB(gv0[1]), .nAandnB(gv0[2]), .nAorB(gv0[3]),
        .nAornB(gv0[4]), .nAandB(gv0[5]),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_vec(fv0), .dbg_state(st0)
    );

    demorgan_equiv_checker #(.SETTLE_CYCLES(S1), .PASSES(P1), .CNT_W(W1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .A(a1), .B(b1),
        .nA(gv1[0]), .nB(gv1[1]), .nAandnB(gv1[2]), .nAorB(gv1[3]),
        .nAornB(gv1[4]), .nAandB(gv1[5]),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_vec(fv1), .dbg_state(st1)
    );

    // ---------------- gate model with fault injection ----------------
    // fault mode per output: 0 good, 1 stuck-0, 2 stuck-1, 3 inverted
    logic [1:0] fm [6];

    function automatic logic golden(input int k, input logic a, input logic b);
        case (k)
            0:       return ~a;
            1:       return ~b;
            2, 3:    return ~(a | b);
            default: return ~(a & b);
        endcase
    endfunction

    function automatic logic faulty(input logic good, input logic [1:0] mode);
        case (mode)
            2'd0:    return good;
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return ~good;
        endcase
    endfunction

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            gv0[k] = faulty(golden(k, a0, b0), fm[k]) ^ junk0[k];
            gv1[k] = faulty(golden(k, a1, b1), fm[k]) ^ junk1[k];
        end
    end

    // ---------------- observation mux ----------------
    int         sel;
    logic       o_a, o_b, o_busy, o_done, o_pass;
    logic [7:0] o_err;
    logic [3:0] o_fv;

    always_comb begin
        if (sel == 0) begin
            o_a = a0; o_b = b0; o_busy = busy0; o_done = done0; o_pass = pass0;
            o_err = err0; o_fv = fv0;
        end else begin
            o_a = a1; o_b = b1; o_busy = busy1; o_done = done1; o_pass = pass1;
            o_err = {6'd0, err1}; o_fv = fv1;
        end
    end

    // ---------------- scoreboard state ----------------
    int         errors = 0;
    int         checks = 0;
    logic [1:0] exp_q[$];
    logic [3:0] m_fv;
    int         m_err;
    logic       m_pass;

    // Reference model: count failing vectors over all passes, then saturate
    task automatic model_run(input int s_p, input int s_w);
        int nf;
        int maxc;
        nf   = 0;
        m_fv = 4'd0;
        exp_q.delete();
        for (int p = 0; p < s_p; p++) begin
            for (int v = 0; v < 4; v++) begin
                logic a, b, f;
                a = ((v >> 1) & 1) != 0;
                b = (v & 1) != 0;
                f = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    if (k >= 2 || INTERM) begin
                        if (faulty(golden(k, a, b), fm[k]) != golden(k, a, b)) f = 1'b1;
                    end
                end
                if (f) begin
                    nf++;
                    m_fv[v] = 1'b1;
                end
                exp_q.push_back(2'(v));
            end
        end
        maxc   = (1 << s_w) - 1;
        m_err  = (nf > maxc) ? maxc : nf;
        m_pass = (nf == 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_start(input int which, input logic val);
        if (which == 0) start0 = val; else start1 = val;
    endtask

    task automatic set_junk(input int which, input logic [5:0] val);
        if (which == 0) junk0 = val; else junk1 = val;
    endtask

    task automatic clear_faults();
        for (int k = 0; k < 6; k++) fm[k] = 2'd0;
    endtask

    // One full run on the selected DUT: timing, vector order and results
    task automatic run_check(input int which, input string tag, input bit glitch);
        int s, p, w, t;
        logic [1:0] ev;
        s = (which == 0) ? S0 : S1;
        p = (which == 0) ? P0 : P1;
        w = (which == 0) ? W0 : W1;
        t = p * 4 * (s + 2);
        sel = which;
        model_run(p, w);
        @(negedge clk);
        set_start(which, 1'b1);
        for (int c = 1; c <= t + 2; c++) begin
            @(negedge clk);
            if (c == 1) set_start(which, 1'b0);
            if (glitch && c <= t && ((c - 1) % (s + 2)) != (s + 1))
                set_junk(which, 6'($urandom_range(0, 63)));
            else
                set_junk(which, 6'd0);
            if (o_busy !== (c <= t)) begin
                errors++;
                $display("FAIL %s busy c=%0d got=%b exp=%b", tag, c, o_busy, (c <= t));
            end
            checks++;
            if (o_done !== (c == t + 1)) begin
                errors++;
                $display("FAIL %s done c=%0d got=%b exp=%b", tag, c, o_done, (c == t + 1));
            end
            checks++;
            if (c <= t && ((c - 1) % (s + 2)) == 0) begin
                ev = exp_q.pop_front();
                if ({o_a, o_b} !== ev) begin
                    errors++;
                    $display("FAIL %s vector c=%0d got=%b%b exp=%b", tag, c, o_a, o_b, ev);
                end
                checks++;
            end
            if (c == 1) begin
                if (o_err !== 8'd0 || o_fv !== 4'd0 || o_pass !== 1'b0) begin
                    errors++;
                    $display("FAIL %s clear_on_start err=%0d fv=%b pass=%b exp 0/0000/0",
                             tag, o_err, o_fv, o_pass);
                end
                checks++;
            end
            if (c >= t + 1) begin
                if ({o_a, o_b} !== 2'b11) begin
                    errors++;
                    $display("FAIL %s ab_hold c=%0d got=%b%b exp=11", tag, c, o_a, o_b);
                end
                checks++;
                if (o_err !== 8'(m_err)) begin
                    errors++;
                    $display("FAIL %s err_count c=%0d got=%0d exp=%0d", tag, c, o_err, m_err);
                end
                checks++;
                if (o_fv !== m_fv) begin
                    errors++;
                    $display("FAIL %s fail_vec c=%0d got=%b exp=%b", tag, c, o_fv, m_fv);
                end
                checks++;
                if (o_pass !== m_pass) begin
                    errors++;
                    $display("FAIL %s pass c=%0d got=%b exp=%b", tag, c, o_pass, m_pass);
                end
                checks++;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        junk0 = 6'd0; junk1 = 6'd0;
        clear_faults();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d;
            #0;
            if ({o_a, o_b, o_busy, o_done, o_pass} !== 5'd0 || o_err !== 8'd0 || o_fv !== 4'd0) begin
                errors++;
                $display("FAIL reset_values dut%0d ab=%b%b busy=%b done=%b pass=%b err=%0d fv=%b exp all 0",
                         d, o_a, o_b, o_busy, o_done, o_pass, o_err, o_fv);
            end
            checks++;
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_sweep();
        clear_faults();
        run_check(0, "clean_dut0", 1'b0);
        run_check(1, "clean_dut1", 1'b0);
    endtask

    task automatic test_or_stuck();
        clear_faults();
        fm[3] = 2'd1;   // nAorB stuck at 0
        run_check(0, "nAorB_stuck0", 1'b0);
    endtask

    task automatic test_saturation();
        clear_faults();
        fm[5] = 2'd2;   // nAandB stuck at 1
        run_check(1, "nAandB_stuck1", 1'b0);
        fm[2] = 2'd3;   // nAandnB inverted as well
        run_check(1, "saturate", 1'b0);
    endtask

    task automatic test_interm();
        clear_faults();
        fm[1] = 2'd1;   // nB stuck at 0
        run_check(0, "nB_stuck0", 1'b0);
    endtask

    task automatic test_reset_mid_run();
        clear_faults();
        fm[3] = 2'd1;   // makes v=0 fail so results are non-zero before reset
        sel = 0;
        @(negedge clk);
        start0 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start0 = 1'b0;
        end
        // cycle 10 is the first SETTLE cycle of v=2
        if ({o_a, o_b} !== 2'b10 || o_err !== 8'd1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset ab=%b%b err=%0d busy=%b exp=10/1/1", o_a, o_b, o_err, o_busy);
        end
        checks++;
        #1 reset = 1'b1;
        #1;
        if ({o_a, o_b, o_busy, o_done, o_pass} !== 5'd0 || o_err !== 8'd0 || o_fv !== 4'd0) begin
            errors++;
            $display("FAIL async_reset ab=%b%b busy=%b done=%b pass=%b err=%0d fv=%b exp all 0",
                     o_a, o_b, o_busy, o_done, o_pass, o_err, o_fv);
        end
        checks++;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL abandoned_run c=%0d done=%b busy=%b exp=0/0", c, o_done, o_busy);
            end
            checks++;
        end
        run_check(0, "after_reset", 1'b0);
    endtask

    task automatic test_start_held();
        logic eb, ed, ep;
        clear_faults();
        sel = 0;
        @(negedge clk);
        start0 = 1'b1;
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            if (c == 36) start0 = 1'b0;
            eb = (c >= 1 && c <= 16) || (c >= 19 && c <= 34);
            ed = (c == 17) || (c == 35);
            ep = (c == 17) || (c == 18) || (c >= 35);
            if (o_busy !== eb) begin
                errors++;
                $display("FAIL held_busy c=%0d got=%b exp=%b", c, o_busy, eb);
            end
            checks++;
            if (o_done !== ed) begin
                errors++;
                $display("FAIL held_done c=%0d got=%b exp=%b", c, o_done, ed);
            end
            checks++;
            if (o_pass !== ep) begin
                errors++;
                $display("FAIL held_pass c=%0d got=%b exp=%b", c, o_pass, ep);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < 6; k++) begin
                fm[k] = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            end
            run_check(i % 2, "random", 1'b1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        sel = 0;
        test_reset();
        test_clean_sweep();
        test_or_stuck();
        test_saturation();
        test_interm();
        test_reset_mid_run();
        test_start_held();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demorgan_equiv_checker.md
# demorgan_equiv_checker

Sequencing stimulus-and-check stage for the De Morgan gate blocks. On a `start` pulse it drives all four `{A,B}` combinations into a NOT/OR/AND equivalence pair, waits a programmable settle time per vector, and samples the four single-bit results. It checks each result against the golden function and reports a per-vector failure map, a saturating error count and a pass/fail verdict. It sits directly upstream (drives `A`, `B`) and downstream (consumes results) of the gate-level De Morgan modules in the lab bench and FPGA self-test wrapper.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles the vector is held before sampling; 0 is legal.
- `PASSES`, default 1: full 4-vector sweeps per run; must be ≥1.
- `CNT_W`, default 8: width of `err_count`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  run request; sampled only in IDLE.
- `A`, `B`  out  1 each  stimulus to the gate blocks.
- `nA`, `nB`  in  1 each  intermediate complements returned by the gate block.
- `nAandnB`, `nAorB`  in  1 each  NOT/OR pair results.
- `nAornB`, `nAandB`  in  1 each  NOT/AND pair results.
- `busy`  out  1  high from the cycle after `start` is accepted through the last CHECK.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  verdict; valid from `done` until the next accepted `start`.
- `err_count`  out  CNT_W  failing vectors this run; saturates.
- `fail_vec`  out  4  sticky per-vector fail flags; bit index = `{A,B}`.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: `start`=1 → DRIVE. Clears `err_count`, `fail_vec`, `pass`, vector index v=0, pass counter p=0. `start` outside IDLE is ignored, including in DONE.
- DRIVE (1 cycle): `A`=v[1], `B`=v[0]. Next state is SETTLE if SETTLE_CYCLES>0, else CHECK.
- SETTLE: hold the vector for exactly SETTLE_CYCLES cycles, then go to CHECK.
- CHECK (1 cycle): with golden values g_or=~(A|B) and g_and=~(A&B), the vector fails if `nAandnB`≠g_or, `nAorB`≠g_or, `nAornB`≠g_and, or `nAandB`≠g_and.
  - On failure: `fail_vec[v]` is set, and `err_count` increments by exactly 1 per failing vector, saturating at all-ones.
  - Then: if v<3, v+1 → DRIVE. If v=3 and p<PASSES-1, v=0, p+1 → DRIVE. Otherwise → DONE.
- DONE (1 cycle): `done`=1; `pass` is set to (`err_count`==0 and no failure found in the final CHECK). Next state is IDLE.
- `A`/`B` hold the last driven vector until the next run or reset.
- Reset mid-run: the run is abandoned with no `done`. All outputs go to reset values; a fresh `start` is required.

## Timing
- Reset values: `A`=0, `B`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, state IDLE.
- All outputs are registered. `A`/`B` change on the clock edge that enters DRIVE.
- Per vector: SETTLE_CYCLES+2 cycles (DRIVE + SETTLE + CHECK).
- Run length: `start` is sampled at edge 0. The first DRIVE is cycle 1. `done` is high in cycle PASSES·4·(SETTLE_CYCLES+2)+1. Defaults: `done` in cycle 17.
- Result inputs are sampled only on the CHECK edge; glitches at other times are ignored.
- `err_count`/`fail_vec` update on the CHECK edge and are visible the next cycle. Final values are stable while `done`=1.

## Configuration
- `DEMORGAN_CHK_INTERM_EN` defined: CHECK additionally fails the vector if `nA`≠~A or `nB`≠~B. This is still one increment per vector.
- Not defined: `nA`/`nB` ports remain present but are ignored. No logic reads them.

## Test plan
- Correct gate model, defaults, `start` pulse at cycle 0 → `busy` 1..16, `done` at cycle 17, `pass`=1, `err_count`=0, `fail_vec`=4'b0000, vectors in order 00, 01, 10, 11.
- `nAorB` stuck at 0 → vectors 01, 10, 11 are correct and only v=0 fails (golden 1) → `err_count`=1, `fail_vec`=4'b0001, `pass`=0.
- `nAandB` stuck at 1, CNT_W=2, PASSES=2 → v=3 fails twice → `err_count`=2, `fail_vec`=4'b1000. With `nAandnB` also inverted, 8 failures → `err_count` saturates at 3.
- `reset` asserted mid-SETTLE of v=2 → outputs at reset values immediately, no `done`. A fresh `start` runs a full 16-cycle sweep.
- `start` held high throughout → exactly one run per IDLE visit; `start` during DONE is ignored, so the next run begins from IDLE.
- `DEMORGAN_CHK_INTERM_EN` defined, `nB` stuck at 0 → vectors 00 and 10 fail → `fail_vec`=4'b0101, `err_count`=2. Same fault without the macro → `pass`=1.
